// File: rtl/posit_encode_accum_prod_es3_pkg.sv
// Shared definitions for the es=3 product-accumulator encoder.
//   - posit width / scale limits for the default 32-bit build
//   - serialized accumulator layout {sgn, scale, fraction, inf, zero}, MSB first
//   - value_accum_prod struct matching that layout
//   - shift_right: right shift with a caller-chosen fill bit
package posit_defines_es3;

  localparam int POSIT_NBITS_ES3    = 32;
  localparam int POSIT_MAXSCALE_ES3 = 240;
  localparam int POSIT_ES_ES3       = 3;

  localparam int SCALE_BITS_ACCUM = 10;
  localparam int FBITS_ACCUM      = 32;
  localparam int POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3 = 1 + SCALE_BITS_ACCUM + FBITS_ACCUM + 2;

  // Bit offsets inside the serialized accumulator word
  localparam int ACC_ZERO_OFS  = 0;
  localparam int ACC_INF_OFS   = 1;
  localparam int ACC_FRAC_OFS  = 2;
  localparam int ACC_SCALE_OFS = ACC_FRAC_OFS + FBITS_ACCUM;
  localparam int ACC_SGN_OFS   = ACC_SCALE_OFS + SCALE_BITS_ACCUM;

  typedef struct packed {
    logic                               sgn;
    logic signed [SCALE_BITS_ACCUM-1:0] scale;
    logic [FBITS_ACCUM-1:0]             fraction;
    logic                               inf;
    logic                               zero;
  } value_accum_prod;

  typedef value_accum_prod accum_prod_es3_t;

  typedef enum logic [2:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_NAR,
    CLS_MAXP,
    CLS_MINP
  } enc_cls_e;

  // Working vector for regime insertion: {lead bit, e, fraction} at the top,
  // padded below so a regime of up to NBITS bits never pushes payload off the end.
  localparam int SHIFT_W = POSIT_NBITS_ES3 + 1 + POSIT_ES_ES3 + FBITS_ACCUM;

  function automatic logic [SHIFT_W-1:0] shift_right(input logic [SHIFT_W-1:0] v,
                                                     input logic [6:0]         sh,
                                                     input logic               fill);
    logic [2*SHIFT_W-1:0] ext;
    ext = {{SHIFT_W{fill}}, v} >> sh;
    return ext[SHIFT_W-1:0];
  endfunction

endpackage

// File: rtl/posit_encode_accum_prod_es3_round.sv
// posit_round_rne_es3: combinational round-to-nearest-even and sign stage.
//   body   : NBITS-1 kept magnitude bits (regime, exponent, fraction)
//   guard  : first dropped bit
//   sticky : OR of all further dropped bits
//   sgn    : negate result when set
//   posit  : rounded, clamped, signed posit
// Rounding never overflows into the sign bit (clamps to maxpos) and never
// reaches zero (clamps to minpos).
module posit_round_rne_es3 #(
  parameter int NBITS = 32
) (
  input  logic [NBITS-2:0] body,
  input  logic             guard,
  input  logic             sticky,
  input  logic             sgn,
  output logic [NBITS-1:0] posit
);

  logic             rup;
  logic [NBITS-1:0] sum;
  logic [NBITS-1:0] mag;

  assign rup = guard & (body[0] | sticky);
  assign sum = {1'b0, body} + {{(NBITS-1){1'b0}}, rup};

  always_comb begin
    mag = sum;
    if (sum[NBITS-1])
      mag = {1'b0, {(NBITS-1){1'b1}}};
    else if (sum == '0)
      mag = {{(NBITS-1){1'b0}}, 1'b1};
  end

  assign posit = sgn ? -mag : mag;

endmodule

// File: rtl/posit_encode_accum_prod_es3.sv
// posit_encode_accum_prod_es3: encodes the serialized es=3 product accumulator
// into an NBITS posit (RNE), three pipeline stages, ready/valid both sides.
//   clk, rst (async, active high)
//   in_valid / in_ready / in_accum / in_truncated : accumulator side
//   out_valid / out_ready / out_posit             : writeback side
// Optional build macro POSIT_ENCODE_INEXACT_EN adds out_inexact (guard|sticky
// nonzero or saturation), aligned with out_posit.
// Stages: S1 classify + split scale into k/e, S2 regime insertion and
// guard/sticky extraction, S3 round/sign into the output register.
module posit_encode_accum_prod_es3
  import posit_defines_es3::*;
#(
  parameter int NBITS = POSIT_NBITS_ES3,
  parameter int ES    = POSIT_ES_ES3
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3-1:0] in_accum,
  input  logic                                             in_truncated,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [NBITS-1:0]                                 out_posit
`ifdef POSIT_ENCODE_INEXACT_EN
  ,
  output logic                                             out_inexact
`endif
);

  localparam int STAGES   = 3;
  localparam int MAXSCALE = (NBITS - 2) * 8;
  localparam int PL_W     = 1 + ES + FBITS_ACCUM;
  localparam int PAD_W    = SHIFT_W - PL_W;
  localparam logic signed [SCALE_BITS_ACCUM-1:0] MAXSCALE_S = SCALE_BITS_ACCUM'(MAXSCALE);
  localparam logic signed [SCALE_BITS_ACCUM-1:0] MINSCALE_S = SCALE_BITS_ACCUM'(-MAXSCALE);

  if (ES != 3) begin : g_es_bad
    $error("posit_encode_accum_prod_es3: ES must be 3");
  end
  if (NBITS < 8 || MAXSCALE > POSIT_MAXSCALE_ES3) begin : g_nbits_bad
    $error("posit_encode_accum_prod_es3: NBITS must be 8..32");
  end

  // ---------------- handshake / valid pipe ----------------
  logic              advance;
  logic [STAGES:1]   vld_pipe;

  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vld_pipe <= '0;
    else if (advance)
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // ---------------- S1: unpack / classify ----------------
  accum_prod_es3_t    acc;
  enc_cls_e           cls_d;
  logic signed [6:0]  k_d;

  always_comb begin
    acc.sgn      = in_accum[ACC_SGN_OFS];
    acc.scale    = in_accum[ACC_SCALE_OFS +: SCALE_BITS_ACCUM];
    acc.fraction = in_accum[ACC_FRAC_OFS +: FBITS_ACCUM];
    acc.inf      = in_accum[ACC_INF_OFS];
    acc.zero     = in_accum[ACC_ZERO_OFS];
  end

  always_comb begin
    cls_d = CLS_NORM;
    if (acc.inf)                    cls_d = CLS_NAR;
    else if (acc.zero)              cls_d = CLS_ZERO;
    else if (acc.scale > MAXSCALE_S) cls_d = CLS_MAXP;
    else if (acc.scale < MINSCALE_S) cls_d = CLS_MINP;
  end

  // Only meaningful for CLS_NORM, where |k| <= 30 fits in 7 bits
  assign k_d = 7'(acc.scale >>> ES);

  enc_cls_e               s1_cls;
  logic                   s1_sgn;
  logic signed [6:0]      s1_k;
  logic [ES-1:0]          s1_e;
  logic [FBITS_ACCUM-1:0] s1_frac;
  logic                   s1_trunc;

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_cls   <= cls_d;
      s1_sgn   <= acc.sgn;
      s1_k     <= k_d;
      s1_e     <= acc.scale[ES-1:0];
      s1_frac  <= acc.fraction;
      s1_trunc <= in_truncated;
    end
  end

  // ---------------- S2: regime insertion ----------------
  // k>=0: shift {0,e,f} right by k+1 filling ones -> 1..10 e f
  // k<0 : shift {1,e,f} right by -k   filling zeros -> 0..01 e f
  logic               neg_k;
  logic [6:0]         shamt;
  logic [SHIFT_W-1:0] shifted;
  logic [NBITS-2:0]   body_n;
  logic               guard_n;
  logic               sticky_n;

  assign neg_k   = s1_k[6];
  assign shamt   = neg_k ? 7'(-s1_k) : 7'(s1_k + 7'sd1);
  assign shifted = shift_right({neg_k, s1_e, s1_frac, {PAD_W{1'b0}}}, shamt, ~neg_k);

  always_comb begin
    body_n   = shifted[SHIFT_W-1 -: NBITS-1];
    guard_n  = shifted[SHIFT_W-NBITS];
    sticky_n = (|shifted[SHIFT_W-NBITS-1:0]) | s1_trunc;
    case (s1_cls)
      CLS_MAXP: begin
        body_n   = '1;
        guard_n  = 1'b0;
        sticky_n = 1'b0;
      end
      CLS_MINP: begin
        body_n   = {{(NBITS-2){1'b0}}, 1'b1};
        guard_n  = 1'b0;
        sticky_n = 1'b0;
      end
      default: ;
    endcase
  end

  enc_cls_e         s2_cls;
  logic             s2_sgn;
  logic [NBITS-2:0] s2_body;
  logic             s2_guard;
  logic             s2_sticky;

  always_ff @(posedge clk) begin
    if (advance) begin
      s2_cls    <= s1_cls;
      s2_sgn    <= s1_sgn;
      s2_body   <= body_n;
      s2_guard  <= guard_n;
      s2_sticky <= sticky_n;
    end
  end

  // ---------------- S3: round / sign / specials ----------------
  logic [NBITS-1:0] rnd_posit;
  logic [NBITS-1:0] res;

  posit_round_rne_es3 #(.NBITS(NBITS)) u_round (
    .body   (s2_body),
    .guard  (s2_guard),
    .sticky (s2_sticky),
    .sgn    (s2_sgn),
    .posit  (rnd_posit)
  );

  always_comb begin
    res = rnd_posit;
    if (s2_cls == CLS_NAR)
      res = {1'b1, {(NBITS-1){1'b0}}};
    else if (s2_cls == CLS_ZERO)
      res = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_posit <= '0;
    else if (advance && vld_pipe[STAGES-1])
      out_posit <= res;
  end

`ifdef POSIT_ENCODE_INEXACT_EN
  logic inx_n;
  logic s2_inx;

  always_comb begin
    inx_n = 1'b0;
    case (s1_cls)
      CLS_NORM:           inx_n = (|shifted[SHIFT_W-NBITS:0]) | s1_trunc;
      CLS_MAXP, CLS_MINP: inx_n = 1'b1;
      default:            inx_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (advance)
      s2_inx <= inx_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_inexact <= 1'b0;
    else if (advance && vld_pipe[STAGES-1])
      out_inexact <= s2_inx;
  end
`endif

endmodule
